// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, opcode and datapath-select encodings for the multi-cycle RV32I sequencer
package ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM_ADDR, S_MEM, S_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;
    localparam logic [1:0] A_RS1     = 2'b00;
    localparam logic [1:0] A_OLD_PC  = 2'b01;
    localparam logic [1:0] A_ZERO    = 2'b10;
    localparam logic [1:0] B_RS2     = 2'b00;
    localparam logic [1:0] B_IMM     = 2'b01;
    localparam logic [1:0] B_FOUR    = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;
    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
    } moore_t;
    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LUI, OP_AUIPC: return S_EXEC;
            OP_LOAD, OP_STORE:            return S_MEM_ADDR;
            OP_BRANCH:                    return S_BRANCH;
            OP_JAL, OP_JALR:              return S_JUMP;
            default:                      return S_TRAP;
        endcase
    endfunction
    function automatic moore_t moore_out(input state_t s, input logic [6:0] op);
        moore_t m;
        m = '0;
        case (s)
            S_FETCH:    m.imem_req = 1'b1;
            S_DECODE: begin
                m.alu_src_a = A_OLD_PC;
                m.alu_src_b = B_IMM;
            end
            S_EXEC: begin
                m.alu_src_a = op == OP_LUI ? A_ZERO : op == OP_AUIPC ? A_OLD_PC : A_RS1;
                m.alu_src_b = op == OP_R ? B_RS2 : B_IMM;
                m.alu_op    = (op == OP_R || op == OP_I) ? ALU_FUNCT : ALU_ADD;
            end
            S_MEM_ADDR: m.alu_src_b = B_IMM;
            S_MEM: begin
                m.dmem_req = 1'b1;
                m.dmem_we  = op == OP_STORE;
            end
            S_WB: begin
                m.reg_write = 1'b1;
                m.wb_sel    = op == OP_LOAD ? WB_MDR : WB_ALU;
            end
            S_BRANCH:   m.alu_op = ALU_BR;
            S_JUMP: begin
                m.reg_write = 1'b1;
                m.wb_sel    = WB_PC4;
                m.alu_src_b = op == OP_JALR ? B_IMM : B_RS2;
            end
            default:    m = '0;
        endcase
        return m;
    endfunction
endpackage

// File: rtl/instret_counter.sv
// instret_counter: 32-bit wrapping enable counter with async active-low clear
// ports: clk, rst_n, en (count this cycle), count (current value)
module instret_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (en) count <= count + 32'd1;
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb) with retire counter
// in:  clk, rst_n, opcode/funct3 (IR fields), branch_taken, imem_ready, dmem_ready
// out: imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_sel, alu_src_a/b, alu_op,
//      reg_write, wb_sel, illegal (sticky), retire (pulse), instret
module mc_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        retire,
    output logic [31:0] instret
);
    state_t state, nxt;
    moore_t mo;
    logic   fetch_done, mem_done, unused_funct3;
    assign unused_funct3 = ^funct3;
    // handshakes complete only against the registered request, so ready is ignored elsewhere
    assign fetch_done = mo.imem_req && imem_ready;
    assign mem_done   = mo.dmem_req && dmem_ready;
    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:    nxt = fetch_done ? S_DECODE : S_FETCH;
            S_DECODE:   nxt = decode_next(opcode);
            S_EXEC:     nxt = S_WB;
            S_MEM_ADDR: nxt = S_MEM;
            S_MEM:      nxt = !mem_done ? S_MEM : opcode == OP_LOAD ? S_WB : S_FETCH;
            S_TRAP:     nxt = S_TRAP;
            default:    nxt = S_FETCH;
        endcase
    end
    // Moore outputs are registered from the next state so reset forces them all low
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= S_FETCH;
            mo      <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= nxt;
            mo      <= moore_out(nxt, opcode);
            illegal <= illegal || nxt == S_TRAP;
        end
    assign imem_req  = mo.imem_req;
    assign dmem_req  = mo.dmem_req;
    assign dmem_we   = mo.dmem_we;
    assign alu_src_a = mo.alu_src_a;
    assign alu_src_b = mo.alu_src_b;
    assign alu_op    = mo.alu_op;
    assign reg_write = mo.reg_write;
    assign wb_sel    = mo.wb_sel;
    assign ir_write  = fetch_done;
    assign pc_write  = fetch_done || (state == S_BRANCH && branch_taken) || state == S_JUMP;
    assign pc_sel    = state == S_JUMP ? (opcode == OP_JALR ? PC_ALU : PC_ALUOUT) :
                       (state == S_BRANCH && branch_taken) ? PC_ALUOUT : PC_PLUS4;
    assign retire    = state == S_WB || state == S_BRANCH || state == S_JUMP ||
                       (state == S_MEM && mem_done && opcode == OP_STORE);
    instret_counter u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire),
        .count (instret)
    );
endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control sequencer for the RV32I core. It replaces single-cycle decode with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It issues request/ready handshakes to instruction and data memory and drives the shared ALU, register-file and PC-update controls. It sits between the IR/opcode fields and the datapath muxes, and also keeps a retired-instruction counter.

## Interface
- No parameters; all encodings are fixed and live in the package.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: IR[6:0]; only valid from DECODE onward.
- `funct3` in 3: IR[14:12], passed to the datapath.
- `branch_taken` in 1: comparator result for the current rs1/rs2.
- `imem_ready` in 1: instruction memory handshake completion.
- `dmem_ready` in 1: data memory handshake completion.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data write enable.
- `ir_write` out 1: load IR and OLD_PC.
- `pc_write` out 1: PC register enable.
- `pc_sel` out 2: 00 PC+4, 01 ALUOUT register, 10 ALU result.
- `alu_src_a` out 2: 00 RS1, 01 OLD_PC, 10 zero.
- `alu_src_b` out 2: 00 RS2, 01 IMM, 10 const 4.
- `alu_op` out 2: 00 add, 01 branch compare, 10 funct-decoded.
- `reg_write` out 1: register file write enable.
- `wb_sel` out 2: 00 ALU, 01 MDR, 10 PC+4.
- `illegal` out 1: sticky; set on an unknown opcode.
- `retire` out 1: one-cycle pulse per completed instruction.
- `instret` out 32: count of retired instructions.

## Operation
- States are FETCH, DECODE, EXEC, MEM_ADDR, MEM, WB, BRANCH, JUMP and TRAP.
- **FETCH**
  - Holds `imem_req=1` until `imem_ready=1`.
  - In the ready cycle it asserts `ir_write=1`, `pc_write=1` and `pc_sel=00`, then moves to DECODE.
- **DECODE**
  - Drives `alu_src_a=01`, `alu_src_b=01` and `alu_op=00`; the datapath latches OLD_PC+imm into ALUOUT.
  - Next state by opcode:
    - 0110011, 0010011, 0110111, 0010111 → EXEC.
    - 0000011, 0100011 → MEM_ADDR.
    - 1100011 → BRANCH.
    - 1101111, 1100111 → JUMP.
    - Any other opcode → TRAP.
- **EXEC**
  - R-type: `alu_src_a=00`, `alu_src_b=00`, `alu_op=10`.
  - I-ALU: `alu_src_a=00`, `alu_src_b=01`, `alu_op=10`.
  - LUI: `alu_src_a=10`, `alu_src_b=01`, `alu_op=00`.
  - AUIPC: `alu_src_a=01`, `alu_src_b=01`, `alu_op=00`.
  - Next state is WB with `wb_sel=00`.
- **MEM_ADDR**: drives `alu_src_a=00`, `alu_src_b=01`, `alu_op=00`, then goes to MEM.
- **MEM**
  - Holds `dmem_req=1`, with `dmem_we=1` for stores.
  - On `dmem_ready`:
    - A load goes to WB with `wb_sel=01`.
    - A store retires and returns to FETCH.
- **WB**: `reg_write=1`; the instruction retires and the FSM returns to FETCH.
- **BRANCH**
  - Drives `alu_src_a=00`, `alu_src_b=00`, `alu_op=01`.
  - If `branch_taken`: `pc_write=1`, `pc_sel=01`.
  - Retires and returns to FETCH.
- **JUMP**
  - Always `reg_write=1`, `wb_sel=10`, `pc_write=1`.
  - JAL: `pc_sel=01`.
  - JALR: `pc_sel=10` with `alu_src_a=00`, `alu_src_b=01`, `alu_op=00`; the datapath clears bit 0.
  - Retires and returns to FETCH.
- **TRAP**
  - Asserts `illegal=1` and issues no requests.
  - Stays in TRAP until reset.
- **Decode of opcode per state**
  - The latched next-state choice and the EXEC/MEM/JUMP sub-decode come from `opcode`.
  - `opcode` is stable from DECODE until the next FETCH completes.
- **Retire counter**
  - `retire` pulses in the final cycle of each instruction.
  - `instret` increments on the following edge and wraps from 0xFFFFFFFF to 0.
- **Unselected signals**: all controls not listed for a state are 0.

## Timing
- **Reset (`rst_n` low)**
  - State goes to FETCH immediately.
  - `instret=0`, `illegal=0`.
  - All outputs are held 0, including `imem_req`.
  - The first `imem_req=1` appears in the first cycle after deassertion.
- **Output timing**
  - Moore outputs: `imem_req`, `dmem_req`, `dmem_we`, the ALU selects, `reg_write`, `wb_sel`, `illegal`.
  - Mealy outputs, combinational on ready or `branch_taken` in the current cycle: `ir_write`, `pc_write` (FETCH/BRANCH), `retire` (MEM store).
- **Handshake rules**
  - A request stays asserted until its ready is sampled high; ready in the same cycle as the request completes in that cycle.
  - Ready seen in a non-requesting state is ignored.
- **Minimum latency with zero-wait memory**
  - ALU/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch and jump: 3 cycles.
- Each memory wait cycle adds 1 to the latency.
- Asserting reset mid-MEM drops `dmem_req` asynchronously with no write committed by this block.

## Structure
- **Package `ctrl_pkg`**
  - State enum.
  - Opcode constants.
  - Encodings for `alu_op`, `pc_sel`, `alu_src_a/b` and `wb_sel`.
- **Sub-module `instret_counter`**
  - 32-bit enable counter with async active-low clear.
- The FSM next-state logic and output decode stay in `mc_ctrl_fsm`.

## Test plan
- **Reset.** Hold reset, then release with `imem_ready=1` and opcode 0110011 → cycle-by-cycle `imem_req`, `ir_write`, then EXEC `alu_op=10`, then WB `reg_write=1`; `retire` at cycle 4; `instret=1`.
- **Load with fetch wait states.** Load opcode 0000011 with `imem_ready` delayed 2 cycles and `dmem_ready` delayed 3 cycles → `imem_req` high for 3 cycles, `dmem_req` high for 4 cycles, `dmem_we=0`, WB `wb_sel=01`.
- **Store.** Opcode 0100011 with `dmem_ready=1` → `dmem_we=1` in MEM, no `reg_write`, `retire` in the MEM cycle.
- **Branch.** Opcode 1100011:
  - `branch_taken=1` → `pc_write=1`, `pc_sel=01`.
  - `branch_taken=0` → `pc_write=0`.
- **Jumps and illegal opcode.**
  - JALR → `pc_sel=10`, `wb_sel=10`, `reg_write=1`.
  - Opcode 1111111 → TRAP with `illegal=1` sticky and no requests for 20 cycles.
  - Reset clears it.
- **Counter and reset mid-access.**
  - Preload `instret` to 0xFFFFFFFF via a backdoor and retire one instruction → reads 0.
  - Assert `rst_n` mid-MEM → `dmem_req` drops asynchronously.
